// File: rtl/lutram_bit_loader_pkg.sv
// Shared state type and sizing constants for the LUTRAM bit loader and its
// serializer.
package lutram_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int ADDR_W_DEFAULT = 7;
  localparam int BITCNT_W       = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/lutram_bit_loader_if.sv
// Byte-stream valid/ready handshake feeding the LUTRAM bit loader.
interface lutram_bit_loader_if;
  import lutram_loader_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/lutram_bit_loader_serializer.sv
// Holds the accepted byte and presents one bit per write cycle, LSB or MSB
// first, flagging the final bit of the byte.
module lutram_bit_serializer
  import lutram_loader_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] data_in,
  output logic              bit_out,
  output logic              last
);

  logic [BYTE_W-1:0]   sr_q, sr_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;

  // Load a fresh byte, or move the next bit into the output position.
  always_comb begin
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    if (load) begin
      sr_d     = data_in;
      bitcnt_d = '0;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[BYTE_W-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[BYTE_W-1:1]};
      end
      bitcnt_d = bitcnt_q + BITCNT_W'(1);
    end else begin
      sr_d     = sr_q;
      bitcnt_d = bitcnt_q;
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= '0;
      bitcnt_q <= '0;
    end else begin
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign bit_out = MSB_FIRST ? sr_q[BYTE_W-1] : sr_q[0];
  assign last    = (bitcnt_q == BITCNT_W'(BYTE_W - 1));

endmodule

// File: rtl/lutram_bit_loader.sv
// Write-side sequencer for a 128x1 dual-port LUTRAM: serialises bytes into
// single-bit writes at an auto-incrementing address, or bulk-clears the RAM.
module lutram_bit_loader
  import lutram_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  lutram_bit_loader_if.slave  in_if,
  input  logic                clear_start,
  input  logic                clear_val,
  output logic [ADDR_W-1:0]   ram_a,
  output logic                ram_we,
  output logic                ram_d,
  output logic [ADDR_W-1:0]   wr_ptr,
  output logic                busy,
  output logic                wrapped
);

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_d_q, ram_d_d;
  logic              wrapped_q, wrapped_d;
  logic              clr_val_q, clr_val_d;
  logic              ser_load, ser_shift, ser_bit, ser_last;
  logic              accept;

  // clear_start blocks the handshake so a simultaneous byte stays pending.
  assign in_if.in_ready = (state_q == IDLE) && !clear_start && !rst;
  assign accept         = in_if.in_valid && in_if.in_ready;

  lutram_bit_serializer #(
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .data_in (in_if.in_data),
    .bit_out (ser_bit),
    .last    (ser_last)
  );

  // Next-state and next-output logic; RAM port values hold outside writes.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    ram_a_d   = ram_a_q;
    ram_we_d  = 1'b0;
    ram_d_d   = ram_d_q;
    wrapped_d = wrapped_q;
    clr_val_d = clr_val_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          clr_val_d = clear_val;
          cnt_d     = '0;
          state_d   = CLEAR;
        end else if (accept) begin
          ser_load = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        ram_we_d  = 1'b1;
        ram_a_d   = wr_ptr_q;
        ram_d_d   = ser_bit;
        ser_shift = 1'b1;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        if (wr_ptr_q == PTR_MAX) begin
          wrapped_d = 1'b1;
        end else begin
          wrapped_d = wrapped_q;
        end
        if (ser_last) begin
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      CLEAR: begin
        ram_we_d = 1'b1;
        ram_a_d  = cnt_q;
        ram_d_d  = clr_val_q;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == PTR_MAX) begin
          wr_ptr_d  = '0;
          wrapped_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      ram_a_q   <= '0;
      ram_we_q  <= 1'b0;
      ram_d_q   <= 1'b0;
      wrapped_q <= 1'b0;
      clr_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      ram_a_q   <= ram_a_d;
      ram_we_q  <= ram_we_d;
      ram_d_q   <= ram_d_d;
      wrapped_q <= wrapped_d;
      clr_val_q <= clr_val_d;
    end
  end

  assign ram_a   = ram_a_q;
  assign ram_we  = ram_we_q;
  assign ram_d   = ram_d_q;
  assign wr_ptr  = wr_ptr_q;
  assign wrapped = wrapped_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_lutram_bit_loader.sv
// Bench for lutram_bit_loader: directed scenarios plus randomized traffic,
// checked against a bit-level RAM model built from byte/clear semantics.
module tb_lutram_bit_loader;

  logic       clk;
  logic       rst;
  logic       clear_start;
  logic       clear_val;
  logic [6:0] ram_a;
  logic       ram_we;
  logic       ram_d;
  logic [6:0] wr_ptr;
  logic       busy;
  logic       wrapped;

  lutram_bit_loader_if bif();

  lutram_bit_loader #(
    .ADDR_W    (7),
    .MSB_FIRST (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bif),
    .clear_start (clear_start),
    .clear_val   (clear_val),
    .ram_a       (ram_a),
    .ram_we      (ram_we),
    .ram_d       (ram_d),
    .wr_ptr      (wr_ptr),
    .busy        (busy),
    .wrapped     (wrapped)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Physical RAM as the DUT's write port fills it, plus a write log.
  logic       ram_act [128];
  logic [7:0] wlog [$];

  // Expected RAM contents and pointer state from byte/clear semantics.
  logic exp_ram [128];
  int   exp_ptr;
  logic exp_wrapped;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we === 1'b1) begin
      ram_act[ram_a] <= ram_d;
      wlog.push_back({ram_a, ram_d});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic model_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_ram[exp_ptr] = b[i];
      if (exp_ptr == 127) exp_wrapped = 1'b1;
      exp_ptr = (exp_ptr + 1) % 128;
    end
  endtask

  task automatic model_clear(input logic v);
    for (int a = 0; a < 128; a++) exp_ram[a] = v;
    exp_ptr     = 0;
    exp_wrapped = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bif.in_valid = 1'b0;
    @(negedge clk);
    rst          = 1'b0;
    exp_ptr      = 0;
    exp_wrapped  = 1'b0;
  endtask

  task automatic offer_byte(input logic [7:0] b, input logic drop_after, output int hs_cyc);
    int k;
    k = 0;
    bif.in_valid = 1'b1;
    bif.in_data  = b;
    #1;
    while (bif.in_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (bif.in_ready !== 1'b1) begin
      n_checks++; n_fails++;
      $display("FAIL handshake_timeout: in_ready=%b required 1", bif.in_ready);
    end
    @(posedge clk);
    hs_cyc = cyc;
    @(negedge clk);
    if (drop_after) bif.in_valid = 1'b0;
    else bif.in_valid = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(busy === 1'b0 && ram_we === 1'b0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_checks++; n_fails++;
      $display("FAIL idle_timeout: busy=%b ram_we=%b required 0/0", busy, ram_we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_start = 1'b0; clear_val = 1'b0;
    bif.in_valid = 1'b0; bif.in_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (ram_we !== 1'b0)  begin n_fails++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_checks++; if (ram_a !== 7'd0)   begin n_fails++; $display("FAIL reset_ram_a: got %0d want 0", ram_a); end
    n_checks++; if (ram_d !== 1'b0)   begin n_fails++; $display("FAIL reset_ram_d: got %b want 0", ram_d); end
    n_checks++; if (wr_ptr !== 7'd0)  begin n_fails++; $display("FAIL reset_wr_ptr: got %0d want 0", wr_ptr); end
    n_checks++; if (busy !== 1'b0)    begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (wrapped !== 1'b0) begin n_fails++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
    n_checks++; if (bif.in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready_in_rst: got %b want 0", bif.in_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (bif.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready_after: got %b want 1", bif.in_ready); end
    exp_ptr = 0; exp_wrapped = 1'b0;
  endtask

  task automatic test_single_byte();
    int hs, base, first_we, first_rdy, we_cnt;
    logic exp_d;
    base = wlog.size(); first_we = 0; first_rdy = 0; we_cnt = 0;
    offer_byte(8'hA5, 1'b1, hs);
    model_byte(8'hA5);
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL byte_busy: got %b want 1", busy); end
    for (int idx = 1; idx <= 12; idx++) begin
      if (idx > 1) @(negedge clk);
      if (ram_we === 1'b1) begin
        we_cnt++;
        if (first_we == 0) first_we = idx;
      end
      if (bif.in_ready === 1'b1 && first_rdy == 0) first_rdy = idx;
    end
    n_checks++; if (we_cnt != 8)    begin n_fails++; $display("FAIL byte_we_cycles: got %0d want 8", we_cnt); end
    n_checks++; if (first_we != 2)  begin n_fails++; $display("FAIL byte_first_we: got %0d want 2", first_we); end
    n_checks++; if (first_rdy != 9) begin n_fails++; $display("FAIL byte_ready_again: got %0d want 9", first_rdy); end
    n_checks++; if (wr_ptr !== 7'd8) begin n_fails++; $display("FAIL byte_wr_ptr: got %0d want 8", wr_ptr); end
    n_checks++;
    if (wlog.size() != base + 8) begin
      n_fails++; $display("FAIL byte_log_len: got %0d want %0d", wlog.size() - base, 8);
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_d = 1'((8'hA5 >> i) & 8'h01);
        n_checks++;
        if (wlog[base+i] !== {7'(i), exp_d}) begin
          n_fails++; $display("FAIL byte_write%0d: got a=%0d d=%b want a=%0d d=%b", i, wlog[base+i][7:1], wlog[base+i][0], i, exp_d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs [16];
    int h, base;
    logic exp_d;
    do_reset();
    base = wlog.size();
    for (int i = 0; i < 16; i++) begin
      offer_byte(8'(i), 1'b0, hs[i]);
      bif.in_data = 8'hFF;
      model_byte(8'(i));
    end
    bif.in_valid = 1'b0;
    wait_idle();
    for (int i = 1; i < 16; i++) begin
      n_checks++;
      if (hs[i] - hs[i-1] != 9) begin n_fails++; $display("FAIL b2b_spacing%0d: got %0d want 9", i, hs[i] - hs[i-1]); end
    end
    n_checks++;
    if (wlog.size() != base + 128) begin
      n_fails++; $display("FAIL b2b_log_len: got %0d want 128", wlog.size() - base);
    end else begin
      for (int k = 0; k < 128; k++) begin
        exp_d = 1'(((k >> 3) >> (k & 7)) & 1);
        n_checks++;
        if (wlog[base+k] !== {7'(k), exp_d}) begin
          n_fails++; $display("FAIL b2b_write%0d: got a=%0d d=%b want a=%0d d=%b", k, wlog[base+k][7:1], wlog[base+k][0], k, exp_d);
        end
      end
    end
    n_checks++; if (wr_ptr !== 7'd0)  begin n_fails++; $display("FAIL b2b_wr_ptr: got %0d want 0", wr_ptr); end
    n_checks++; if (wrapped !== 1'b1) begin n_fails++; $display("FAIL b2b_wrapped: got %b want 1", wrapped); end
    base = wlog.size();
    offer_byte(8'hFF, 1'b1, h);
    model_byte(8'hFF);
    wait_idle();
    n_checks++;
    if (wlog.size() != base + 8) begin
      n_fails++; $display("FAIL wrap_byte_log_len: got %0d want 8", wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (wlog[base+i] !== {7'(i), 1'b1}) begin
          n_fails++; $display("FAIL wrap_byte_write%0d: got a=%0d d=%b want a=%0d d=1", i, wlog[base+i][7:1], wlog[base+i][0], i);
        end
      end
    end
  endtask

  task automatic test_clear_priority();
    int base, first_rdy;
    base = wlog.size(); first_rdy = 0;
    clear_start = 1'b1; clear_val = 1'b1;
    bif.in_valid = 1'b1; bif.in_data = 8'h00;
    #1;
    n_checks++; if (bif.in_ready !== 1'b0) begin n_fails++; $display("FAIL clr_in_ready: got %b want 0", bif.in_ready); end
    @(posedge clk);
    @(negedge clk);
    clear_start = 1'b0;
    model_clear(1'b1);
    for (int idx = 1; idx <= 300; idx++) begin
      if (idx > 1) @(negedge clk);
      #1;
      if (bif.in_ready === 1'b1) begin first_rdy = idx; break; end
    end
    n_checks++; if (first_rdy != 129) begin n_fails++; $display("FAIL clr_duration: got %0d want 129", first_rdy); end
    n_checks++; if (wrapped !== 1'b0) begin n_fails++; $display("FAIL clr_wrapped: got %b want 0", wrapped); end
    n_checks++; if (wr_ptr !== 7'd0)  begin n_fails++; $display("FAIL clr_wr_ptr: got %0d want 0", wr_ptr); end
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    model_byte(8'h00);
    wait_idle();
    n_checks++;
    if (wlog.size() != base + 136) begin
      n_fails++; $display("FAIL clr_log_len: got %0d want 136", wlog.size() - base);
    end else begin
      for (int k = 0; k < 136; k++) begin
        n_checks++;
        if (wlog[base+k] !== {7'(k % 128), (k < 128) ? 1'b1 : 1'b0}) begin
          n_fails++; $display("FAIL clr_write%0d: got a=%0d d=%b want a=%0d d=%b", k, wlog[base+k][7:1], wlog[base+k][0], k % 128, k < 128);
        end
      end
    end
  endtask

  task automatic test_clear_ignored_in_shift();
    int hs, base;
    logic exp_d;
    base = wlog.size();
    offer_byte(8'h3C, 1'b1, hs);
    model_byte(8'h3C);
    @(negedge clk);
    @(negedge clk);
    clear_start = 1'b1; clear_val = 1'b0;
    @(negedge clk);
    clear_start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL ign_busy: got %b want 0", busy); end
    n_checks++; if (wr_ptr !== 7'(exp_ptr)) begin n_fails++; $display("FAIL ign_wr_ptr: got %0d want %0d", wr_ptr, exp_ptr); end
    n_checks++;
    if (wlog.size() != base + 8) begin
      n_fails++; $display("FAIL ign_log_len: got %0d want 8", wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_d = 1'((8'h3C >> i) & 8'h01);
        n_checks++;
        if (wlog[base+i] !== {7'(8 + i), exp_d}) begin
          n_fails++; $display("FAIL ign_write%0d: got a=%0d d=%b want a=%0d d=%b", i, wlog[base+i][7:1], wlog[base+i][0], 8 + i, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int hs, base;
    do_reset();
    base = wlog.size();
    offer_byte(8'hFF, 1'b1, hs);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ram_we !== 1'b0) begin n_fails++; $display("FAIL rst_mid_ram_we: got %b want 0", ram_we); end
    n_checks++; if (wr_ptr !== 7'd0) begin n_fails++; $display("FAIL rst_mid_wr_ptr: got %0d want 0", wr_ptr); end
    n_checks++; if (busy !== 1'b0)   begin n_fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_ram[i] = 1'b1;
    exp_ptr = 0; exp_wrapped = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wlog.size() != base + 3) begin n_fails++; $display("FAIL rst_mid_writes: got %0d want 3", wlog.size() - base); end
    for (int a = 0; a < 8; a++) begin
      n_checks++;
      if (ram_act[a] !== exp_ram[a]) begin n_fails++; $display("FAIL rst_mid_ram%0d: got %b want %b", a, ram_act[a], exp_ram[a]); end
    end
  endtask

  task automatic test_random();
    int hs, gap;
    logic [7:0] b;
    logic v;
    for (int op = 0; op < 48; op++) begin
      gap = $urandom_range(0, 3);
      bif.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        wait_idle();
        v = 1'($urandom_range(0, 1));
        clear_start = 1'b1; clear_val = v;
        model_clear(v);
        @(negedge clk);
        clear_start = 1'b0;
      end else begin
        b = 8'($urandom);
        offer_byte(b, 1'(gap & 1), hs);
        bif.in_data = 8'($urandom);
        model_byte(b);
      end
    end
    bif.in_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    for (int a = 0; a < 128; a++) begin
      n_checks++;
      if (ram_act[a] !== exp_ram[a]) begin n_fails++; $display("FAIL rand_ram%0d: got %b want %b", a, ram_act[a], exp_ram[a]); end
    end
    n_checks++; if (wr_ptr !== 7'(exp_ptr)) begin n_fails++; $display("FAIL rand_wr_ptr: got %0d want %0d", wr_ptr, exp_ptr); end
    n_checks++; if (wrapped !== exp_wrapped) begin n_fails++; $display("FAIL rand_wrapped: got %b want %b", wrapped, exp_wrapped); end
  endtask

  initial begin
    for (int a = 0; a < 128; a++) begin
      ram_act[a] = 1'b0;
      exp_ram[a] = 1'b0;
    end
    exp_ptr = 0; exp_wrapped = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_clear_priority();
    test_clear_ignored_in_shift();
    test_reset_mid_shift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lutram_bit_loader.md
Name: lutram_bit_loader

Overview:
Write-side sequencer that sits directly upstream of a 128x1 dual-port LUTRAM (RAM128X1D-class primitive) and drives its WCLK-domain write port (A, WE, D).
- Accepts bytes over a valid/ready handshake and serialises each byte into 8 consecutive single-bit writes at an auto-incrementing address.
- Also provides a bulk-clear sequence that writes a constant to all 128 locations.
- The RAM's read port (DPRA/DPO) stays with the downstream consumer and is not touched by this block.

Parameters:
ADDR_W, 7, RAM address width; depth is 2**ADDR_W (128).
MSB_FIRST, 0, 0 = byte bit 0 is written first; 1 = bit 7 is written first.

Ports:
clk  in  1  single clock; also drives the RAM WCLK.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  byte offered.
in_ready  out  1  byte accepted when in_valid && in_ready.
in_data  in  8  byte to serialise.
clear_start  in  1  single-cycle request to fill the whole RAM with clear_val.
clear_val  in  1  fill value, sampled together with clear_start.
ram_a  out  ADDR_W  RAM write address.
ram_we  out  1  RAM write enable.
ram_d  out  1  RAM write data.
wr_ptr  out  ADDR_W  next address to be written.
busy  out  1  high while in SHIFT or CLEAR.
wrapped  out  1  sticky; set when wr_ptr wraps from 2**ADDR_W-1 to 0 during SHIFT.

Behaviour:
- Reset values (register outputs after any clk edge with rst=1): state=IDLE, wr_ptr=0, ram_a=0, ram_we=0, ram_d=0, wrapped=0, busy=0.
- in_ready = (state==IDLE) && !clear_start && !rst.
- ram_a, ram_we and ram_d come straight from registers. There is no combinational path from any input to them.

State machine (IDLE, SHIFT, CLEAR):
- IDLE, clear_start=1: latch clear_val, set cnt=0, go to CLEAR. clear_start takes priority over in_valid in the same cycle.
- IDLE, handshake at edge T: latch in_data into the shift register, set bitcnt=0, go to SHIFT.
- SHIFT (8 cycles, T+1..T+8): ram_we=1, ram_a=wr_ptr, ram_d = current bit (LSB or MSB per MSB_FIRST). Each cycle: wr_ptr increments mod 2**ADDR_W, the shift register shifts, bitcnt increments. When bitcnt==7, go to IDLE. in_ready is high again at T+9, so sustained throughput is 1 byte per 9 cycles.
- CLEAR (128 cycles): ram_we=1, ram_a=cnt, ram_d=latched clear_val; cnt increments 0..127. On the last write: wr_ptr=0, wrapped=0, go to IDLE.
- clear_start is ignored outside IDLE.
- Wrap: wr_ptr goes 127 -> 0 without stalling. wrapped sets on the cycle the 127 write occurs during SHIFT. wrapped clears only on reset or on completion of CLEAR.
- In all cycles not in SHIFT/CLEAR: ram_we=0. ram_a and ram_d hold their last values (not cleared).
- Reset mid-SHIFT or mid-CLEAR: aborts at the sampling edge, so ram_we=0 from the next cycle. Bits already written remain in the RAM; the remainder of the byte or clear is lost. wr_ptr returns to 0.
- in_data is sampled only at the handshake. Changes to it during SHIFT have no effect.

Decomposition:
- Package lutram_loader_pkg holds:
  - a state enum (IDLE, SHIFT, CLEAR);
  - the constants BYTE_W=8 and the default ADDR_W=7.
- One natural sub-module: lutram_bit_serializer. It contains the 8-bit shift register, bitcnt, MSB_FIRST select and a last-bit flag.
- The top FSM owns the address counter, the clear counter and the handshake.

Test Plan:
1. Reset, then byte 0xA5 with MSB_FIRST=0 -> ram_we=1 for exactly 8 cycles. Writes are addr 0..7 with d=1,0,1,0,0,1,0,1. in_ready=1 again 9 cycles after the handshake. wr_ptr=8.
2. 16 back-to-back bytes 0x00..0x0F (in_valid held high) -> 128 writes; the last is addr 127. wr_ptr=0, wrapped=1. The 17th byte 0xFF writes addr 0..7 to 1.
3. clear_start with clear_val=1 in the same cycle as in_valid with in_data=0x00 -> clear wins and in_ready=0 that cycle. 128 writes of d=1 to addr 0..127. Then wrapped=0, wr_ptr=0, and the pending byte is accepted in the next IDLE cycle.
4. clear_start pulsed during SHIFT -> ignored: no CLEAR entry, and the byte completes normally.
5. rst asserted on the 4th SHIFT cycle of byte 0xFF -> exactly 3 prior writes (addr 0..2, d=1). ram_we=0 from the cycle after rst is sampled. wr_ptr=0, busy=0.
6. Golden RAM model on the bench: random bytes/clears with random in_valid gaps, checking every RAM bit against the model.
